// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised sync FIFO family: count-width helper
// and the aggregated error-status word that parent blocks collect.
package fifo_pkg;

  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic overflow;
    logic underflow;
  } fifo_err_t;

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Modulo-DEPTH pointer. It wraps explicitly at DEPTH-1, so any depth works,
// including depths that are not a power of two.
module fifo_wrap_ptr #(
  parameter int  DEPTH = 8,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  logic [PW-1:0] ptr_d;
  logic [PW-1:0] ptr_q;

  // next-pointer select: clear dominates, then wrap-or-increment
  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      if (ptr_q == PW'(DEPTH - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = ptr_q + PW'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO: any DEPTH >= 2, FWFT or registered-read output, occupancy
// count, almost-full/empty thresholds, flush and sticky error flags.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int  DEPTH     = 8,
  parameter type DTYPE     = int,
  parameter int  FWFT      = 0,
  parameter int  AF_THRESH = 6,
  parameter int  AE_THRESH = 1,
  localparam int CW        = fifo_cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          fifo_wreq,
  input  DTYPE          din,
  input  logic          fifo_rreq,
  output DTYPE          dout,
  output logic          dout_valid,
  output logic          empty,
  output logic          full,
  output logic          almost_empty,
  output logic          almost_full,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic          underflow,
  input  logic          err_clr
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          wr_ok;
  logic          rd_ok;

  logic [CW-1:0] count_d, count_q;
  logic          empty_d, empty_q;
  logic          full_d, full_q;
  logic          ae_d, ae_q;
  logic          af_d, af_q;
  fifo_err_t     err_d, err_q;

  DTYPE mem [DEPTH];

  assign wr_ok = fifo_wreq && !full_q && !flush;
  assign rd_ok = fifo_rreq && !empty_q && !flush;

  fifo_wrap_ptr #(.DEPTH(DEPTH)) u_wptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (wr_ok),
    .ptr (wptr)
  );

  fifo_wrap_ptr #(.DEPTH(DEPTH)) u_rptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (rd_ok),
    .ptr (rptr)
  );

  // occupancy, status decode from next count, and sticky errors (set beats clear)
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    empty_d = (count_d == '0);
    full_d  = (count_d == CW'(DEPTH));
    ae_d    = (count_d <= CW'(AE_THRESH));
    af_d    = (count_d >= CW'(AF_THRESH));

    err_d = err_q;
    if (fifo_wreq && full_q && !flush) begin
      err_d.overflow = 1'b1;
    end else if (err_clr) begin
      err_d.overflow = 1'b0;
    end else begin
      err_d.overflow = err_q.overflow;
    end
    if (fifo_rreq && empty_q && !flush) begin
      err_d.underflow = 1'b1;
    end else if (err_clr) begin
      err_d.underflow = 1'b0;
    end else begin
      err_d.underflow = err_q.underflow;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ae_q    <= 1'b1;
      af_q    <= (AF_THRESH == 0);
      err_q   <= '0;
    end else begin
      count_q <= count_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      ae_q    <= ae_d;
      af_q    <= af_d;
      err_q   <= err_d;
    end
  end

  // storage array, deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wptr] <= din;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign dout       = empty_q ? '0 : mem[rptr];
      assign dout_valid = !empty_q;
    end else begin : g_reg
      DTYPE dout_d, dout_q;
      logic dv_d, dv_q;

      // registered read: capture head on a pop, hold otherwise
      always_comb begin
        if (rd_ok) begin
          dout_d = mem[rptr];
        end else begin
          dout_d = dout_q;
        end
        dv_d = rd_ok;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dout_q <= '0;
          dv_q   <= 1'b0;
        end else begin
          dout_q <= dout_d;
          dv_q   <= dv_d;
        end
      end

      assign dout       = dout_q;
      assign dout_valid = dv_q;
    end
  endgenerate

  assign count        = count_q;
  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_empty = ae_q;
  assign almost_full  = af_q;
  assign overflow     = err_q.overflow;
  assign underflow    = err_q.underflow;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench: a registered-read and an FWFT instance share one stimulus stream.
module tb_param_sync_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       wreq = 1'b0;
  logic       rreq = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] din = 8'h00;

  logic [7:0] dout0, dout1;
  logic       dv0, dv1, empty0, empty1, full0, full1, ae0, ae1, af0, af1;
  logic       ovf0, ovf1, udf0, udf1;
  logic [2:0] cnt0, cnt1;
  logic [5:0] st0, st1;

  int total = 0;
  int bad   = 0;

  // status bits: {empty, full, almost_empty, almost_full, overflow, underflow}
  assign st0 = {empty0, full0, ae0, af0, ovf0, udf0};
  assign st1 = {empty1, full1, ae1, af1, ovf1, udf1};

  always #5 clk = ~clk;

  param_sync_fifo #(.DEPTH(5), .DTYPE(logic [7:0]), .FWFT(0), .AF_THRESH(4), .AE_THRESH(1)) u0 (
    .clk(clk), .rst(rst), .flush(flush), .fifo_wreq(wreq), .din(din), .fifo_rreq(rreq),
    .dout(dout0), .dout_valid(dv0), .empty(empty0), .full(full0), .almost_empty(ae0),
    .almost_full(af0), .count(cnt0), .overflow(ovf0), .underflow(udf0), .err_clr(err_clr));

  param_sync_fifo #(.DEPTH(5), .DTYPE(logic [7:0]), .FWFT(1), .AF_THRESH(4), .AE_THRESH(1)) u1 (
    .clk(clk), .rst(rst), .flush(flush), .fifo_wreq(wreq), .din(din), .fifo_rreq(rreq),
    .dout(dout1), .dout_valid(dv1), .empty(empty1), .full(full1), .almost_empty(ae1),
    .almost_full(af1), .count(cnt1), .overflow(ovf1), .underflow(udf1), .err_clr(err_clr));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] v);
    din = v; wreq = 1'b1; tick(); wreq = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++;
    if (cnt0 !== 3'd0 || st0 !== 6'b101000 || dout0 !== 8'h00 || dv0 !== 1'b0) begin
      bad++; $display("FAIL reset0: cnt=%0d st=%b dout=%h dv=%b want 0 101000 00 0", cnt0, st0, dout0, dv0);
    end
    total++;
    if (cnt1 !== 3'd0 || st1 !== 6'b101000 || dout1 !== 8'h00 || dv1 !== 1'b0) begin
      bad++; $display("FAIL reset1: cnt=%0d st=%b dout=%h dv=%b want 0 101000 00 0", cnt1, st1, dout1, dv1);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fill_drain();
    logic [5:0] exp_st;
    for (int i = 1; i <= 5; i++) begin
      din = 8'(17 * i); wreq = 1'b1; tick();
      exp_st = {1'b0, (i == 5), (i <= 1), (i >= 4), 2'b00};
      total++;
      if (cnt0 !== 3'(i) || st0 !== exp_st || dv0 !== 1'b0) begin
        bad++; $display("FAIL fill0: cnt=%0d st=%b dv=%b want %0d %b 0", cnt0, st0, dv0, i, exp_st);
      end
      total++;
      if (cnt1 !== 3'(i) || st1 !== exp_st || dout1 !== 8'h11 || dv1 !== 1'b1) begin
        bad++; $display("FAIL fill1: cnt=%0d st=%b dout=%h want %0d %b 11", cnt1, st1, dout1, i, exp_st);
      end
    end
    wreq = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      rreq = 1'b1;
      total++;
      if (dout1 !== 8'(17 * i) || dv1 !== 1'b1) begin
        bad++; $display("FAIL drain1: dout=%h dv=%b want %h 1", dout1, dv1, 8'(17 * i));
      end
      tick();
      total++;
      if (dout0 !== 8'(17 * i) || dv0 !== 1'b1 || cnt0 !== 3'(5 - i)) begin
        bad++; $display("FAIL drain0: dout=%h dv=%b cnt=%0d want %h 1 %0d", dout0, dv0, cnt0, 8'(17 * i), 5 - i);
      end
    end
    rreq = 1'b0; tick();
    total++;
    if (dv0 !== 1'b0 || dout0 !== 8'h55 || st0 !== 6'b101000) begin
      bad++; $display("FAIL idle0: dv=%b dout=%h st=%b want 0 55 101000", dv0, dout0, st0);
    end
    total++;
    if (dv1 !== 1'b0 || st1 !== 6'b101000 || cnt1 !== 3'd0) begin
      bad++; $display("FAIL idle1: dv=%b st=%b cnt=%0d want 0 101000 0", dv1, st1, cnt1);
    end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 5; i++) push(8'(17 * i));
    din = 8'h66; wreq = 1'b1; tick(); wreq = 1'b0;
    total++;
    if (st0 !== 6'b010110 || st1 !== 6'b010110 || cnt0 !== 3'd5) begin
      bad++; $display("FAIL ovf_set: st0=%b st1=%b cnt=%0d want 010110 5", st0, st1, cnt0);
    end
    tick();
    total++;
    if (ovf0 !== 1'b1 || ovf1 !== 1'b1) begin
      bad++; $display("FAIL ovf_sticky: got %b%b want 11", ovf0, ovf1);
    end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    total++;
    if (st0 !== 6'b010100 || st1 !== 6'b010100) begin
      bad++; $display("FAIL ovf_clr: st0=%b st1=%b want 010100", st0, st1);
    end
    for (int i = 1; i <= 5; i++) begin
      rreq = 1'b1;
      total++;
      if (dout1 !== 8'(17 * i)) begin
        bad++; $display("FAIL ovf_data1: got %h want %h", dout1, 8'(17 * i));
      end
      tick();
      total++;
      if (dout0 !== 8'(17 * i)) begin
        bad++; $display("FAIL ovf_data0: got %h want %h", dout0, 8'(17 * i));
      end
    end
    rreq = 1'b0; tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_v;
    push(8'h30); push(8'h31); push(8'h32);
    for (int j = 0; j < 10; j++) begin
      exp_v = (j < 3) ? 8'(8'h30 + j) : 8'(8'h40 + j - 3);
      din = 8'(8'h40 + j); wreq = 1'b1; rreq = 1'b1;
      total++;
      if (dout1 !== exp_v) begin
        bad++; $display("FAIL b2b1: got %h want %h", dout1, exp_v);
      end
      tick();
      total++;
      if (dout0 !== exp_v || dv0 !== 1'b1 || cnt0 !== 3'd3 || cnt1 !== 3'd3) begin
        bad++; $display("FAIL b2b0: dout=%h cnt0=%0d cnt1=%0d want %h 3 3", dout0, cnt0, cnt1, exp_v);
      end
    end
    wreq = 1'b0;
    for (int j = 0; j < 3; j++) begin
      rreq = 1'b1;
      total++;
      if (dout1 !== 8'(8'h47 + j)) begin
        bad++; $display("FAIL b2b_tail1: got %h want %h", dout1, 8'(8'h47 + j));
      end
      tick();
      total++;
      if (dout0 !== 8'(8'h47 + j)) begin
        bad++; $display("FAIL b2b_tail0: got %h want %h", dout0, 8'(8'h47 + j));
      end
    end
    rreq = 1'b0; tick();
  endtask

  task automatic test_empty();
    rreq = 1'b1; tick(); rreq = 1'b0;
    total++;
    if (st0 !== 6'b101001 || st1 !== 6'b101001 || dv0 !== 1'b0) begin
      bad++; $display("FAIL udf_set: st0=%b st1=%b dv0=%b want 101001 0", st0, st1, dv0);
    end
    tick();
    total++;
    if (udf0 !== 1'b1 || dv0 !== 1'b0 || cnt0 !== 3'd0) begin
      bad++; $display("FAIL udf_sticky: udf=%b dv=%b cnt=%0d want 1 0 0", udf0, dv0, cnt0);
    end
    err_clr = 1'b1; rreq = 1'b1; tick(); rreq = 1'b0;
    total++;
    if (udf0 !== 1'b1 || udf1 !== 1'b1) begin
      bad++; $display("FAIL set_wins: got %b%b want 11", udf0, udf1);
    end
    tick(); err_clr = 1'b0;
    total++;
    if (st0 !== 6'b101000 || st1 !== 6'b101000) begin
      bad++; $display("FAIL udf_clr: st0=%b st1=%b want 101000", st0, st1);
    end
    push(8'hA5);
    total++;
    if (dout1 !== 8'hA5 || dv1 !== 1'b1 || dv0 !== 1'b0) begin
      bad++; $display("FAIL fwft_a5: dout1=%h dv1=%b dv0=%b want a5 1 0", dout1, dv1, dv0);
    end
    rreq = 1'b1; tick(); rreq = 1'b0;
    total++;
    if (dout0 !== 8'hA5 || dv0 !== 1'b1) begin
      bad++; $display("FAIL reg_a5: dout0=%h dv0=%b want a5 1", dout0, dv0);
    end
    tick();
  endtask

  task automatic test_flush();
    rreq = 1'b1; tick(); rreq = 1'b0;
    for (int i = 1; i <= 4; i++) push(8'(8'h50 + i));
    total++;
    if (cnt0 !== 3'd4 || st0 !== 6'b000101 || st1 !== 6'b000101) begin
      bad++; $display("FAIL pre_flush: cnt=%0d st0=%b st1=%b want 4 000101", cnt0, st0, st1);
    end
    flush = 1'b1; wreq = 1'b1; rreq = 1'b1; din = 8'h99; tick();
    flush = 1'b0; wreq = 1'b0; rreq = 1'b0;
    total++;
    if (cnt0 !== 3'd0 || cnt1 !== 3'd0 || st0 !== 6'b101001 || st1 !== 6'b101001 || dv0 !== 1'b0 || dv1 !== 1'b0) begin
      bad++; $display("FAIL flush: cnt=%0d/%0d st=%b/%b dv=%b%b want 0 101001 00", cnt0, cnt1, st0, st1, dv0, dv1);
    end
    push(8'h77);
    rreq = 1'b1;
    total++;
    if (dout1 !== 8'h77 || cnt1 !== 3'd1) begin
      bad++; $display("FAIL post_flush1: dout=%h cnt=%0d want 77 1", dout1, cnt1);
    end
    tick(); rreq = 1'b0;
    total++;
    if (dout0 !== 8'h77 || cnt0 !== 3'd0) begin
      bad++; $display("FAIL post_flush0: dout=%h cnt=%0d want 77 0", dout0, cnt0);
    end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
  endtask

  task automatic test_async_reset();
    push(8'h21); push(8'h22); push(8'h23);
    din = 8'h24; wreq = 1'b1; rreq = 1'b1; tick();
    total++;
    if (dout0 !== 8'h21 || dv0 !== 1'b1 || cnt0 !== 3'd3) begin
      bad++; $display("FAIL burst: dout=%h dv=%b cnt=%0d want 21 1 3", dout0, dv0, cnt0);
    end
    #3 rst = 1'b1;
    #1;
    total++;
    if (cnt0 !== 3'd0 || st0 !== 6'b101000 || dout0 !== 8'h00 || dv0 !== 1'b0) begin
      bad++; $display("FAIL arst0: cnt=%0d st=%b dout=%h dv=%b want 0 101000 00 0", cnt0, st0, dout0, dv0);
    end
    total++;
    if (cnt1 !== 3'd0 || st1 !== 6'b101000 || dout1 !== 8'h00 || dv1 !== 1'b0) begin
      bad++; $display("FAIL arst1: cnt=%0d st=%b dout=%h dv=%b want 0 101000 00 0", cnt1, st1, dout1, dv1);
    end
    wreq = 1'b0; rreq = 1'b0;
    #1 rst = 1'b0;
    push(8'h3C);
    rreq = 1'b1;
    total++;
    if (dout1 !== 8'h3C || dv1 !== 1'b1 || cnt1 !== 3'd1) begin
      bad++; $display("FAIL after_rst1: dout=%h dv=%b cnt=%0d want 3c 1 1", dout1, dv1, cnt1);
    end
    tick(); rreq = 1'b0;
    total++;
    if (dout0 !== 8'h3C || dv0 !== 1'b1 || cnt0 !== 3'd0) begin
      bad++; $display("FAIL after_rst0: dout=%h dv=%b cnt=%0d want 3c 1 0", dout0, dv0, cnt0);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_back_to_back();
    test_empty();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
